// File: rtl/dh_responder.sv
// dh_responder: responder side of a Diffie-Hellman exchange.
// Accepts peer value R1 over a valid/ready handshake and computes
// R2 = G^Y mod P and KEY = R1^Y mod P. Both use an MSB-first
// square-and-multiply loop on a bit-serial interleaved modular multiplier.
// Ports:
//   CLK, RST            clock, asynchronous active-low reset
//   G, P, Y, R1         generator, modulus, private exponent, peer value (sampled at accept)
//   R1_VALID, R1_READY  request handshake (ready only while idle)
//   R2, KEY             registered results
//   DONE, ERR           one-cycle pulses: results updated / request rejected
//   BUSY                high whenever the block is not idle
module dh_responder #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] G,
  input  logic [W-1:0] P,
  input  logic [W-1:0] Y,
  input  logic         R1_VALID,
  input  logic [W-1:0] R1,
  output logic         R1_READY,
  output logic [W-1:0] R2,
  output logic [W-1:0] KEY,
  output logic         DONE,
  output logic         ERR,
  output logic         BUSY
);

  localparam int unsigned BW = $clog2(W);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHK  = 3'd1;
  localparam logic [2:0] S_SQ   = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  g_q, g_d, p_q, p_d, y_q, y_d, r1_q, r1_d;
  logic [W-1:0]  acc_q, acc_d, base_q, base_d, r_q, r_d, r2h_q, r2h_d;
  logic [W-1:0]  r2_q, r2_d, key_q, key_d;
  logic [BW-1:0] bit_q, bit_d, cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          done_q, done_d, err_q, err_d, busy_q, busy_d, rdy_q, rdy_d;

  // Request validity on the live inputs, so ERR can be registered into the CHK cycle
  logic reject_in_c;
  assign reject_in_c = (P < W'(3)) || (G < W'(2)) || (G >= P) ||
                       (R1 == '0) || (R1 >= P);

  // One step of the interleaved multiplier; W+1 bits so 2r and r+a never wrap
  logic [W-1:0] mb_c, mul_r_c;
  logic [W:0]   p_ext_c, dbl_c, red1_c, sum_c, red2_c;
  always_comb begin
    mb_c    = (state_q == S_MUL) ? base_q : acc_q;
    p_ext_c = {1'b0, p_q};
    dbl_c   = {r_q, 1'b0};
    red1_c  = (dbl_c >= p_ext_c) ? (dbl_c - p_ext_c) : dbl_c;
    sum_c   = red1_c + (mb_c[cnt_q] ? {1'b0, acc_q} : '0);
    red2_c  = (sum_c >= p_ext_c) ? (sum_c - p_ext_c) : sum_c;
    mul_r_c = W'(red2_c);
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    y_d     = y_q;
    r1_d    = r1_q;
    acc_d   = acc_q;
    base_d  = base_q;
    r_d     = r_q;
    r2h_d   = r2h_q;
    r2_d    = r2_q;
    key_d   = key_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    rdy_d   = rdy_q;

    case (state_q)
      S_IDLE: begin
        if (R1_VALID) begin
          g_d     = G;
          p_d     = P;
          y_d     = Y;
          r1_d    = R1;
          err_d   = reject_in_c;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CHK;
        end
      end

      S_CHK: begin
        if (err_q) begin
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          acc_d   = W'(1);
          base_d  = g_q;
          bit_d   = BW'(W - 1);
          cnt_d   = BW'(W - 1);
          r_d     = '0;
          phase_d = 1'b0;
          state_d = S_SQ;
        end
      end

      S_SQ, S_MUL: begin
        if (cnt_q != '0) begin
          r_d   = mul_r_c;
          cnt_d = cnt_q - BW'(1);
        end else begin
          // Product complete this cycle
          r_d   = '0;
          cnt_d = BW'(W - 1);
          acc_d = mul_r_c;
          if ((state_q == S_SQ) && y_q[bit_q]) begin
            state_d = S_MUL;
          end else if (bit_q != '0) begin
            bit_d   = bit_q - BW'(1);
            state_d = S_SQ;
          end else if (!phase_q) begin
            // Phase A finished: hold R2, restart the ladder on R1
            r2h_d   = mul_r_c;
            acc_d   = W'(1);
            base_d  = r1_q;
            bit_d   = BW'(W - 1);
            phase_d = 1'b1;
            state_d = S_SQ;
          end else begin
            // Results land together with DONE in the FIN cycle
            key_d   = mul_r_c;
            r2_d    = r2h_q;
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      p_q     <= '0;
      y_q     <= '0;
      r1_q    <= '0;
      acc_q   <= '0;
      base_q  <= '0;
      r_q     <= '0;
      r2h_q   <= '0;
      r2_q    <= '0;
      key_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      y_q     <= y_d;
      r1_q    <= r1_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      r_q     <= r_d;
      r2h_q   <= r2h_d;
      r2_q    <= r2_d;
      key_q   <= key_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign R1_READY = rdy_q;
  assign R2       = r2_q;
  assign KEY      = key_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_dh_responder.sv
// tb_dh_responder: directed and randomized requests against a modular
// exponentiation reference model, with exact DONE/ERR latency checks.
module tb_dh_responder;

  localparam int unsigned W = 32;

  logic         CLK;
  logic         RST;
  logic [W-1:0] G, P, Y, R1;
  logic         R1_VALID;
  logic         R1_READY;
  logic [W-1:0] R2, KEY;
  logic         DONE, ERR, BUSY;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_r2  = '0;
  logic [W-1:0] exp_key = '0;

  dh_responder #(.W(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .G        (G),
    .P        (P),
    .Y        (Y),
    .R1_VALID (R1_VALID),
    .R1       (R1),
    .R1_READY (R1_READY),
    .R2       (R2),
    .KEY      (KEY),
    .DONE     (DONE),
    .ERR      (ERR),
    .BUSY     (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: right-to-left exponentiation with 64-bit arithmetic
  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    longint unsigned r = 1;
    longint unsigned x = 64'(b) % 64'(m);
    for (int i = 0; i < int'(W); i++) begin
      if (e[i]) r = (r * x) % 64'(m);
      x = (x * x) % 64'(m);
    end
    return W'(r);
  endfunction

  function automatic bit rejected(input logic [W-1:0] g, input logic [W-1:0] p,
                                  input logic [W-1:0] r1);
    return (p < 3) || (g < 2) || (g >= p) || (r1 == 0) || (r1 >= p);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_r2"},   64'(R2), 64'(0));
    chk({tag, "_key"},  64'(KEY), 64'(0));
    chk({tag, "_done"}, 64'(DONE), 64'(0));
    chk({tag, "_err"},  64'(ERR), 64'(0));
    chk({tag, "_busy"}, 64'(BUSY), 64'(0));
    chk({tag, "_rdy"},  64'(R1_READY), 64'(1));
  endtask

  // Present a request and return just after its accepting edge
  task automatic issue(input string tag, input logic [W-1:0] g, input logic [W-1:0] p,
                       input logic [W-1:0] y, input logic [W-1:0] r1,
                       input bit skip_wait, input bit keep_valid);
    if (!skip_wait) @(negedge CLK);
    G = g; P = p; Y = y; R1 = r1;
    R1_VALID = 1'b1;
    chk({tag, "_rdy_pre"}, 64'(R1_READY), 64'(1));
    @(posedge CLK);
    #1;
    if (!keep_valid) R1_VALID = 1'b0;
    // Operand buses wander while busy; the block must ignore them
    G = $urandom; P = $urandom; Y = $urandom; R1 = $urandom;
  endtask

  // Count cycles from the accept edge to DONE/ERR and check results
  task automatic await_result(input string tag, input logic [W-1:0] g, input logic [W-1:0] p,
                              input logic [W-1:0] y, input logic [W-1:0] r1);
    bit rej = rejected(g, p, r1);
    int lat = rej ? 1 : 2 + 2 * int'(W) * (int'(W) + $countones(y));
    int n = 0;
    bit seen = 0;
    if (!rej) begin
      exp_r2  = modexp(g, y, p);
      exp_key = modexp(r1, y, p);
    end
    while (!seen && n < lat + 20) begin
      @(negedge CLK);
      n++;
      if (n == 1) begin
        chk({tag, "_busy_chk"}, 64'(BUSY), 64'(1));
        chk({tag, "_rdy_chk"},  64'(R1_READY), 64'(0));
      end
      if (DONE || ERR) seen = 1;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_err"},     64'(ERR), 64'(rej));
    chk({tag, "_done"},    64'(DONE), 64'(!rej));
    chk({tag, "_r2"},      64'(R2), 64'(exp_r2));
    chk({tag, "_key"},     64'(KEY), 64'(exp_key));
    @(negedge CLK);
    chk({tag, "_done_post"}, 64'(DONE), 64'(0));
    chk({tag, "_err_post"},  64'(ERR), 64'(0));
    chk({tag, "_rdy_post"},  64'(R1_READY), 64'(1));
    chk({tag, "_busy_post"}, 64'(BUSY), 64'(0));
  endtask

  task automatic run_req(input string tag, input logic [W-1:0] g, input logic [W-1:0] p,
                         input logic [W-1:0] y, input logic [W-1:0] r1);
    issue(tag, g, p, y, r1, 1'b0, 1'b0);
    await_result(tag, g, p, y, r1);
  endtask

  initial begin
    RST = 1'b0;
    R1_VALID = 1'b0;
    G = '0; P = '0; Y = '0; R1 = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("por");
    RST = 1'b1;

    run_req("basic",   32'd5, 32'd23, 32'd15, 32'd8);
    run_req("y_zero",  32'd5, 32'd23, 32'd0,  32'd8);
    run_req("rej_r1z", 32'd5, 32'd23, 32'd15, 32'd0);
    run_req("rej_r1p", 32'd5, 32'd23, 32'd15, 32'd23);
    run_req("rej_p2",  32'd5, 32'd2,  32'd15, 32'd8);
    run_req("carry",   32'd2, 32'd4294967291, 32'd1, 32'hFFFF_FFF0);

    // Reset in the middle of phase B, then repeat the basic request
    issue("mid_rst", 32'd5, 32'd23, 32'd15, 32'd8, 1'b0, 1'b0);
    repeat (1500) @(negedge CLK);
    RST = 1'b0;
    #1;
    exp_r2 = '0;
    exp_key = '0;
    check_reset_outputs("mid_rst_a");
    repeat (3) @(negedge CLK);
    check_reset_outputs("mid_rst_b");
    RST = 1'b1;
    run_req("after_rst", 32'd5, 32'd23, 32'd15, 32'd8);

    // Valid held high across back-to-back requests
    issue("hold1", 32'd5, 32'd23, 32'd15, 32'd8, 1'b0, 1'b1);
    await_result("hold1", 32'd5, 32'd23, 32'd15, 32'd8);
    issue("hold2", 32'd5, 32'd23, 32'd6, 32'd19, 1'b1, 1'b0);
    await_result("hold2", 32'd5, 32'd23, 32'd6, 32'd19);

    // Randomized requests, a mix of small, full-width and likely-invalid operands
    for (int t = 0; t < 8; t++) begin
      logic [W-1:0] rp, rg, rr1, ry;
      int mode;
      mode = int'($urandom_range(0, 3));
      if (mode == 0) rp = $urandom_range(3, 1000);
      else rp = $urandom | 32'd3;
      rg  = 32'd2 + ($urandom % (rp - 32'd2));
      rr1 = 32'd1 + ($urandom % (rp - 32'd1));
      ry  = $urandom;
      if (mode == 3) rr1 = rp + $urandom_range(0, 5);
      run_req($sformatf("rand%0d", t), rg, rp, ry, rr1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
